iq_multiport: RTL and testbench

IQ_MULTIPORT -- requirements
Module: iq_multiport

---
 rtl/rv32i_types.sv | 14 +
 rtl/iq_multiport.sv | 95 +++++++++
 tb/tb_iq_multiport.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// rv32i_types: shared core-wide sizing constants and small elaboration helpers
package rv32i_types;

  localparam int XLEN           = 32;
  localparam int INSTR_ENTRY_W  = 3 * XLEN;
  localparam int IQ_DEPTH       = 16;
  localparam int FETCH_WIDTH    = 2;
  localparam int DISPATCH_WIDTH = 2;

  function automatic int imax(input int a, input int b);
    return a > b ? a : b;
  endfunction

endpackage

// File: rtl/iq_multiport.sv
// iq_multiport: circular instruction queue with multi-lane enqueue and show-ahead multi-lane dequeue
module iq_multiport
  import rv32i_types::*;
#(
  parameter int DATA_WIDTH = INSTR_ENTRY_W,
  parameter int DEPTH      = IQ_DEPTH,
  parameter int ENQ_W      = FETCH_WIDTH,
  parameter int DEQ_W      = DISPATCH_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [$clog2(ENQ_W+1)-1:0]     enq_cnt,
  input  logic [ENQ_W*DATA_WIDTH-1:0]    enq_data,
  output logic                           enq_ready,
  input  logic [$clog2(DEQ_W+1)-1:0]     deq_cnt,
  output logic [DEQ_W*DATA_WIDTH-1:0]    deq_data,
  output logic [DEQ_W-1:0]               deq_valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = $clog2(ENQ_W+1);
  localparam int QW = $clog2(DEQ_W+1);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 * imax(ENQ_W, DEQ_W)) begin : g_bad_cfg
    $error("iq_multiport: DEPTH must be a power of two and at least 2*max(ENQ_W,DEQ_W)");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         enq_n, deq_n;
  logic                  enq_acc;

  assign enq_ready = count_q <= CW'(DEPTH - ENQ_W);
  assign enq_acc   = enq_ready && enq_cnt != '0 && !flush;
  assign full      = count_q == CW'(DEPTH);
  assign empty     = count_q == '0;
  assign count     = count_q;

  // Accepted lane counts and next pointer/occupancy values; over-asked dequeues saturate at occupancy
  always_comb begin
    enq_n   = enq_acc ? CW'(enq_cnt) : '0;
    deq_n   = CW'(deq_cnt) > count_q ? count_q : CW'(deq_cnt);
    head_d  = head_q + PW'(deq_n);
    tail_d  = tail_q + PW'(enq_n);
    count_d = count_q + enq_n - deq_n;
  end

  // Pointer and occupancy registers; flush wins over any same-cycle enqueue or dequeue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write of the offered lanes at tail onward; contents survive reset and flush
  always_ff @(posedge clk) begin
    if (enq_acc)
      for (int i = 0; i < ENQ_W; i++)
        if (EW'(i) < enq_cnt) mem_q[tail_q + PW'(i)] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Show-ahead read of head..head+DEQ_W-1 from registered state; empty lanes read zero
  always_comb begin
    deq_data  = '0;
    deq_valid = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      deq_valid[i] = CW'(i) < count_q;
      deq_data[i*DATA_WIDTH +: DATA_WIDTH] = deq_valid[i] ? mem_q[head_q + PW'(i)] : '0;
    end
  end

  a_enq_cnt_legal: assert property (@(posedge clk) disable iff (rst) enq_cnt <= EW'(ENQ_W))
    else $error("iq_multiport: enq_cnt exceeds ENQ_W");

  a_deq_cnt_legal: assert property (@(posedge clk) disable iff (rst)
    deq_cnt <= QW'(DEQ_W) && CW'(deq_cnt) <= count_q)
    else $error("iq_multiport: deq_cnt exceeds valid lanes");

endmodule

// File: tb/tb_iq_multiport.sv
// tb_iq_multiport: randomized and directed checks of iq_multiport against a queue-based model
module tb_iq_multiport;

  localparam int DW = 32;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic [1:0]    enq_cnt;
  logic [63:0]   enq_data;
  logic          enq_ready;
  logic [1:0]    deq_cnt;
  logic [63:0]   deq_data;
  logic [1:0]    deq_valid;
  logic [3:0]    count;
  logic          full;
  logic          empty;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [31:0]   mq[$];
  logic [31:0]   dut_pop[$];
  logic [31:0]   mod_pop[$];

  iq_multiport #(.DATA_WIDTH(DW), .DEPTH(D), .ENQ_W(2), .DEQ_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_cnt(enq_cnt), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_cnt(deq_cnt), .deq_data(deq_data), .deq_valid(deq_valid),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic cycle(input int ec, input logic [31:0] a, input logic [31:0] b, input int dc, input bit fl);
    bit rdy;
    int k;
    enq_cnt  = 2'(ec);
    enq_data = {b, a};
    deq_cnt  = 2'(dc);
    flush    = fl;
    if (fl) mq.delete();
    else begin
      for (int i = 0; i < dc && i < 2; i++) dut_pop.push_back(deq_data[i*32 +: 32]);
      rdy = mq.size() <= D - 2;
      k = dc < mq.size() ? dc : mq.size();
      repeat (k) mod_pop.push_back(mq.pop_front());
      if (rdy && ec > 0) begin
        mq.push_back(a);
        if (ec > 1) mq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    enq_cnt = '0;
    deq_cnt = '0;
    flush   = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_chk++; if ({empty, full, enq_ready} !== 3'b101) begin n_fail++; $display("FAIL reset_flags got %b want 101", {empty, full, enq_ready}); end
    n_chk++; if (deq_valid !== 2'b00 || deq_data !== 64'd0) begin n_fail++; $display("FAIL reset_deq got %b/%h want 00/0", deq_valid, deq_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_enq_basic;
    cycle(2, 32'hAAAA_0001, 32'hBBBB_0002, 0, 0);
    n_chk++; if (count !== 4'd2) begin n_fail++; $display("FAIL basic_count got %0d want 2", count); end
    n_chk++; if (deq_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid got %b want 11", deq_valid); end
    n_chk++; if (deq_data !== {32'hBBBB_0002, 32'hAAAA_0001}) begin n_fail++; $display("FAIL basic_lanes got %h want bbbb0002aaaa0001", deq_data); end
  endtask

  task automatic test_full_drop;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(2, 32'(100 + 2*i), 32'(101 + 2*i), 0, 0);
    n_chk++; if (count !== 4'd8 || full !== 1'b1 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got count=%0d full=%b rdy=%b want 8/1/0", count, full, enq_ready); end
    cycle(1, 32'hC, 32'hC, 0, 0);
    n_chk++; if (count !== 4'd8) begin n_fail++; $display("FAIL drop_count got %0d want 8", count); end
    n_chk++; if (deq_data !== {32'd101, 32'd100}) begin n_fail++; $display("FAIL drop_head got %h want head 100,101", deq_data); end
  endtask

  task automatic test_simul_enq_deq;
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(2, 32'(200 + 2*i), 32'(201 + 2*i), 0, 0);
    n_chk++; if (count !== 4'd6 || enq_ready !== 1'b1) begin n_fail++; $display("FAIL six_state got count=%0d rdy=%b want 6/1", count, enq_ready); end
    cycle(2, 32'd206, 32'd207, 1, 0);
    n_chk++; if (count !== 4'd7 || enq_ready !== 1'b0) begin n_fail++; $display("FAIL simul_state got count=%0d rdy=%b want 7/0", count, enq_ready); end
    n_chk++; if (deq_data[31:0] !== 32'd201) begin n_fail++; $display("FAIL simul_head got %0d want 201", deq_data[31:0]); end
  endtask

  task automatic test_flush;
    cycle(0, 0, 0, 0, 1);
    cycle(2, 1, 2, 0, 0);
    cycle(2, 3, 4, 0, 0);
    cycle(1, 5, 0, 0, 0);
    n_chk++; if (count !== 4'd5) begin n_fail++; $display("FAIL pre_flush_count got %0d want 5", count); end
    cycle(2, 6, 7, 1, 1);
    n_chk++; if (count !== 4'd0 || empty !== 1'b1 || deq_valid !== 2'b00) begin n_fail++; $display("FAIL flush_state got count=%0d empty=%b valid=%b want 0/1/00", count, empty, deq_valid); end
    cycle(1, 32'h77, 0, 0, 0);
    n_chk++; if (deq_valid !== 2'b01 || deq_data[31:0] !== 32'h77) begin n_fail++; $display("FAIL post_flush got valid=%b lane0=%h want 01/77", deq_valid, deq_data[31:0]); end
  endtask

  task automatic test_wrap_stream;
    int k;
    cycle(0, 0, 0, 0, 1);
    dut_pop.delete();
    mod_pop.delete();
    for (int i = 0; i < 40; i++) cycle(2, 32'(1000 + 2*i), 32'(1001 + 2*i), mq.size() < 2 ? mq.size() : 2, 0);
    n_chk++; if (dut_pop.size() != 78) begin n_fail++; $display("FAIL wrap_len got %0d want 78", dut_pop.size()); end
    k = 0;
    foreach (dut_pop[i]) if (dut_pop[i] !== 32'(1000 + i)) k++;
    n_chk++; if (k != 0) begin n_fail++; $display("FAIL wrap_seq got %0d out-of-order values want 0", k); end
  endtask

  task automatic test_async_reset;
    cycle(0, 0, 0, 0, 1);
    cycle(2, 11, 12, 0, 0);
    cycle(1, 13, 0, 0, 0);
    n_chk++; if (count !== 4'd3) begin n_fail++; $display("FAIL pre_rst_count got %0d want 3", count); end
    #2;
    rst = 1'b1;
    #1;
    n_chk++; if (count !== 4'd0 || deq_valid !== 2'b00) begin n_fail++; $display("FAIL async_rst got count=%0d valid=%b want 0/00", count, deq_valid); end
    n_chk++; if ({empty, full, enq_ready} !== 3'b101 || deq_data !== 64'd0) begin n_fail++; $display("FAIL async_rst_flags got %b/%h want 101/0", {empty, full, enq_ready}, deq_data); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic test_random;
    int ec, dc;
    logic [1:0] ev;
    logic [63:0] ed;
    int bad = 0;
    dut_pop.delete();
    mod_pop.delete();
    for (int n = 0; n < 400; n++) begin
      ec = $urandom_range(0, 2);
      dc = $urandom_range(0, mq.size() < 2 ? mq.size() : 2);
      cycle(ec, $urandom, $urandom, dc, $urandom_range(0, 24) == 0);
      ev = {mq.size() > 1, mq.size() > 0};
      ed = {mq.size() > 1 ? mq[1] : 32'd0, mq.size() > 0 ? mq[0] : 32'd0};
      n_chk++;
      if (count !== 4'(mq.size()) || deq_valid !== ev || deq_data !== ed ||
          full !== (mq.size() == D) || empty !== (mq.size() == 0) || enq_ready !== (mq.size() <= D - 2)) begin
        n_fail++;
        if (bad++ < 5) $display("FAIL rand_state cyc %0d got count=%0d valid=%b data=%h want count=%0d valid=%b data=%h", n, count, deq_valid, deq_data, mq.size(), ev, ed);
      end
    end
    n_chk++; if (dut_pop != mod_pop) begin n_fail++; $display("FAIL rand_popped got %0d values want %0d matching model", dut_pop.size(), mod_pop.size()); end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    enq_cnt = '0;
    deq_cnt = '0;
    enq_data = '0;
    test_reset;
    test_enq_basic;
    test_full_drop;
    test_simul_enq_deq;
    test_flush;
    test_wrap_stream;
    test_async_reset;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
